// File: rtl/ysyx_23060229_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060229_axi_pkg
// Purpose  : Shared AXI response/burst codes, CLINT register offsets, FSM
//            state types and address helpers for the AXI CLINT slave.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_23060229_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [31:0] CLINT_OFF_LO = 32'd0;
  localparam logic [31:0] CLINT_OFF_HI = 32'd4;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_LO   = 2'd1,
    SEL_HI   = 2'd2
  } clint_sel_e;

  // Which half of mtime a byte address selects; anything else is unmapped.
  function automatic clint_sel_e clint_decode(input logic [31:0] addr,
                                              input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    if (off == CLINT_OFF_LO)      clint_decode = SEL_LO;
    else if (off == CLINT_OFF_HI) clint_decode = SEL_HI;
    else                          clint_decode = SEL_NONE;
  endfunction

  // Next beat address: FIXED holds, INCR and WRAP (treated as INCR) step a word.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [1:0]  burst);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR,
      BURST_WRAP:  next_addr = addr + 32'd4;
      default:     next_addr = addr + 32'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060229_clint_timer.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060229_clint_timer
// Purpose  : 64-bit mtime counter advanced once every DIV clocks, with a
//            byte-granular write port that takes priority over the increment.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060229_clint_timer #(
  parameter int DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  i_wbe,
  input  logic [63:0] i_wdata,
  output logic [63:0] o_mtime
);

  localparam logic [15:0] c_div_last = 16'(DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic        tick;

  // Prescaler rollover produces the tick; a byte write replaces the tick update.
  always_comb begin
    tick    = (presc_q == c_div_last);
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d = mtime_q;
    if (|i_wbe) begin
      for (int b = 0; b < 8; b++) begin
        if (i_wbe[b]) mtime_d[8*b +: 8] = i_wdata[8*b +: 8];
      end
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  // Counter and prescaler state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q <= 16'd0;
      mtime_q <= 64'd0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

  assign o_mtime = mtime_q;

endmodule
`default_nettype wire

// File: rtl/ysyx_23060229_axi_clint.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060229_axi_clint
// Purpose  : AXI4 slave exposing the 64-bit CLINT mtime at BASE_ADDR as two
//            32-bit words. Independent read and write FSMs; reads return a
//            snapshot taken at the AR handshake so bursts never tear.
//            Define YSYX_23060229_CLINT_WRITE_EN to make mtime writable;
//            otherwise writes are drained and answered with SLVERR.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060229_axi_clint
  import ysyx_23060229_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          DIV       = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  output logic        rlast,
  output logic [3:0]  rid,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  input  logic        wlast,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic [3:0]  bid
);

  logic [63:0] mtime;
  logic [7:0]  tm_wbe;
  logic [63:0] tm_wdata;

  ysyx_23060229_clint_timer #(.DIV(DIV)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .i_wbe   (tm_wbe),
    .i_wdata (tm_wdata),
    .o_mtime (mtime)
  );

  // Read-side state
  r_state_e    r_state_q, r_state_d;
  logic        rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [31:0] rdata_q, rdata_d, raddr_q, raddr_d;
  logic [1:0]  rresp_q, rresp_d, rburst_q, rburst_d;
  logic [3:0]  rid_q, rid_d;
  logic [7:0]  rlen_q, rlen_d;
  logic [8:0]  rcnt_q, rcnt_d;
  logic [63:0] snap_q, snap_d;
  logic [33:0] beat;

  // Read data/response for one beat from a given snapshot.
  function automatic logic [33:0] rd_beat(input logic [31:0] addr, input logic [63:0] snap);
    case (clint_decode(addr, BASE_ADDR))
      SEL_LO:  rd_beat = {RESP_OKAY, snap[31:0]};
      SEL_HI:  rd_beat = {RESP_OKAY, snap[63:32]};
      default: rd_beat = {RESP_DECERR, 32'd0};
    endcase
  endfunction

  // Read FSM next state: capture the request and snapshot, then stream beats.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rburst_d  = rburst_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    snap_d    = snap_q;
    beat      = 34'd0;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid) begin
          snap_d    = mtime;
          raddr_d   = araddr;
          rburst_d  = arburst;
          rlen_d    = arlen;
          rid_d     = arid;
          rcnt_d    = 9'd0;
          beat      = rd_beat(araddr, mtime);
          rdata_d   = beat[31:0];
          rresp_d   = beat[33:32];
          rlast_d   = (arlen == 8'd0);
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            raddr_d = next_addr(raddr_q, rburst_q);
            rcnt_d  = rcnt_q + 9'd1;
            beat    = rd_beat(raddr_d, snap_q);
            rdata_d = beat[31:0];
            rresp_d = beat[33:32];
            rlast_d = (rcnt_d == {1'b0, rlen_q});
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read-side registers; reset aborts any burst in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'd0;
      rid_q     <= 4'd0;
      raddr_q   <= 32'd0;
      rburst_q  <= 2'd0;
      rlen_q    <= 8'd0;
      rcnt_q    <= 9'd0;
      snap_q    <= 64'd0;
    end else begin
      r_state_q <= r_state_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rburst_q  <= rburst_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      snap_q    <= snap_d;
    end
  end

  // Ready is a state decode held low during reset so it rises right at release.
  assign arready = (r_state_q == R_IDLE) & ~reset;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rid     = rid_q;

  // Write-side state
  w_state_e    w_state_q, w_state_d;
  logic        wready_q, wready_d, bvalid_q, bvalid_d, werr_q, werr_d, last_beat;
  logic [31:0] waddr_q, waddr_d;
  logic [1:0]  wburst_q, wburst_d, bresp_q, bresp_d;
  logic [3:0]  bid_q, bid_d;
  logic [7:0]  wlen_q, wlen_d;
  logic [8:0]  wcnt_q, wcnt_d;
`ifdef YSYX_23060229_CLINT_WRITE_EN
  logic        wdec_q, wdec_d;
`endif

  // Write FSM next state: AW, then exactly awlen+1 W beats, then B response.
  always_comb begin
    w_state_d = w_state_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    waddr_d   = waddr_q;
    wburst_d  = wburst_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    last_beat = 1'b0;
    tm_wbe    = 8'd0;
    tm_wdata  = 64'd0;
`ifdef YSYX_23060229_CLINT_WRITE_EN
    wdec_d    = wdec_q;
`endif
    case (w_state_q)
      W_IDLE: begin
        if (awvalid) begin
          waddr_d   = awaddr;
          wburst_d  = awburst;
          wlen_d    = awlen;
          bid_d     = awid;
          wcnt_d    = 9'd0;
          werr_d    = 1'b0;
`ifdef YSYX_23060229_CLINT_WRITE_EN
          wdec_d    = 1'b0;
`endif
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          last_beat = (wcnt_q == {1'b0, wlen_q});
          // wlast must coincide with the counted final beat.
          if (wlast != last_beat) werr_d = 1'b1;
`ifdef YSYX_23060229_CLINT_WRITE_EN
          case (clint_decode(waddr_q, BASE_ADDR))
            SEL_LO: begin
              tm_wbe   = {4'd0, wstrb};
              tm_wdata = {32'd0, wdata};
            end
            SEL_HI: begin
              tm_wbe   = {wstrb, 4'd0};
              tm_wdata = {wdata, 32'd0};
            end
            default: wdec_d = 1'b1;
          endcase
`endif
          waddr_d = next_addr(waddr_q, wburst_q);
          wcnt_d  = wcnt_q + 9'd1;
          if (last_beat) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
`ifdef YSYX_23060229_CLINT_WRITE_EN
            if (werr_d)      bresp_d = RESP_SLVERR;
            else if (wdec_d) bresp_d = RESP_DECERR;
            else             bresp_d = RESP_OKAY;
`else
            bresp_d   = RESP_SLVERR;
`endif
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write-side registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'd0;
      bid_q     <= 4'd0;
      waddr_q   <= 32'd0;
      wburst_q  <= 2'd0;
      wlen_q    <= 8'd0;
      wcnt_q    <= 9'd0;
      werr_q    <= 1'b0;
`ifdef YSYX_23060229_CLINT_WRITE_EN
      wdec_q    <= 1'b0;
`endif
    end else begin
      w_state_q <= w_state_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      waddr_q   <= waddr_d;
      wburst_q  <= wburst_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
`ifdef YSYX_23060229_CLINT_WRITE_EN
      wdec_q    <= wdec_d;
`endif
    end
  end

  assign awready = (w_state_q == W_IDLE) & ~reset;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign bid     = bid_q;

  // Transfer size is always a 32-bit word; write data is dropped when read-only.
  logic unused_inputs;
`ifdef YSYX_23060229_CLINT_WRITE_EN
  assign unused_inputs = ^{arsize, awsize};
`else
  assign unused_inputs = ^{arsize, awsize, wdata, wstrb};
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060229_axi_clint.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060229_axi_clint
// Purpose  : Self-checking bench for the AXI CLINT slave. Expected R and B
//            responses are queued when a request is issued and compared when
//            the slave returns them; mtime is tracked by a reference counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060229_axi_clint;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam int          LIM  = 50;

  logic        clk, rst;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [3:0]  arid, rid, awid, bid, wstrb;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, rresp, awburst, bresp;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;

  ysyx_23060229_axi_clint #(.BASE_ADDR(BASE), .DIV(1)) dut (
    .clock(clk), .reset(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .rlast(rlast), .rid(rid),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .bid(bid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rexp_t;

  typedef struct {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  rexp_t rq[$];
  bexp_t bq[$];
  int    n_checks = 0;
  int    n_err    = 0;

  // Reference mtime (DIV=1): one step per clock, a strobed write replaces the step.
  logic [63:0] mdl_mtime;
  logic        mdl_wr;
  logic [7:0]  mdl_wbe;
  logic [63:0] mdl_wdata;

  always @(posedge clk or posedge rst) begin
    if (rst) mdl_mtime <= 64'd0;
    else if (mdl_wr && (|mdl_wbe)) begin
      logic [63:0] m;
      m = mdl_mtime;
      for (int k = 0; k < 8; k++) if (mdl_wbe[k]) m[8*k +: 8] = mdl_wdata[8*k +: 8];
      mdl_mtime <= m;
    end else mdl_mtime <= mdl_mtime + 64'd1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic rexp_t exp_beat(input logic [31:0] a, input logic [63:0] snap,
                                     input logic last, input logic [3:0] id);
    rexp_t e;
    e.last = last;
    e.id   = id;
    if (a == BASE)               begin e.data = snap[31:0];  e.resp = 2'b00; end
    else if (a == BASE + 32'd4)  begin e.data = snap[63:32]; e.resp = 2'b00; end
    else                         begin e.data = 32'd0;       e.resp = 2'b11; end
    return e;
  endfunction

  // Issue one read burst; abort >= 0 pulls reset while that beat is presented.
  task automatic rd(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                    input logic [3:0] id, input int stall, input int abort);
    logic [31:0] a;
    logic [63:0] snap;
    rexp_t       e;
    int          n;
    araddr = addr; arlen = len; arburst = burst; arid = id; arsize = 3'd2; arvalid = 1'b1;
    n = 0;
    while (!arready && n < LIM) begin @(posedge clk); #1; n++; end
    check("arready", arready, 1);
    snap = mdl_mtime;
    a    = addr;
    for (int b = 0; b <= int'(len); b++) begin
      rq.push_back(exp_beat(a, snap, b == int'(len), id));
      if (burst != 2'b00) a = a + 32'd4;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if (b == abort) begin
        #2 rst = 1'b1;
        #1;
        check("abort_rvalid", rvalid, 0);
        check("abort_arready", arready, 0);
        rready = 1'b0;
        rq.delete();
        return;
      end
      if (b == 0) begin
        rready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          check("stall_rvalid", rvalid, 1);
          check("stall_rdata", rdata, rq[0].data);
          check("stall_rresp", rresp, rq[0].resp);
          check("stall_rlast", rlast, rq[0].last);
          @(posedge clk); #1;
        end
      end
      rready = 1'b1;
      n = 0;
      while (!rvalid && n < LIM) begin @(posedge clk); #1; n++; end
      check("rvalid", rvalid, 1);
      e = rq.pop_front();
      check("rdata", rdata, e.data);
      check("rresp", rresp, e.resp);
      check("rlast", rlast, e.last);
      check("rid", rid, e.id);
      @(posedge clk); #1;
    end
    rready = 1'b0;
    check("rvalid_end", rvalid, 0);
  endtask

  // Issue one write burst; wlast is driven on beat index last_at.
  task automatic wr(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                    input logic [31:0] data, input logic [3:0] strb, input int last_at);
    logic [31:0] a;
    logic        lerr;
    bexp_t       e;
    int          n;
`ifdef YSYX_23060229_CLINT_WRITE_EN
    logic        derr;
    derr = 1'b0;
`endif
    awaddr = addr; awlen = len; awid = id; awburst = 2'b01; awsize = 3'd2; awvalid = 1'b1;
    n = 0;
    while (!awready && n < LIM) begin @(posedge clk); #1; n++; end
    check("awready", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    a    = addr;
    lerr = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wdata = data; wstrb = strb; wlast = (b == last_at); wvalid = 1'b1;
      if ((b == int'(len)) != (b == last_at)) lerr = 1'b1;
`ifdef YSYX_23060229_CLINT_WRITE_EN
      if (a == BASE) begin
        mdl_wr = 1'b1; mdl_wbe = {4'd0, strb}; mdl_wdata = {32'd0, data};
      end else if (a == BASE + 32'd4) begin
        mdl_wr = 1'b1; mdl_wbe = {strb, 4'd0}; mdl_wdata = {data, 32'd0};
      end else derr = 1'b1;
`endif
      n = 0;
      while (!wready && n < LIM) begin @(posedge clk); #1; n++; end
      check("wready", wready, 1);
      @(posedge clk); #1;
      mdl_wr = 1'b0;
      a = a + 32'd4;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    check("wready_done", wready, 0);
`ifdef YSYX_23060229_CLINT_WRITE_EN
    e.resp = lerr ? 2'b10 : (derr ? 2'b11 : 2'b00);
`else
    e.resp = 2'b10;
`endif
    e.id = id;
    bq.push_back(e);
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < LIM) begin @(posedge clk); #1; n++; end
    check("bvalid", bvalid, 1);
    e = bq.pop_front();
    check("bresp", bresp, e.resp);
    check("bid", bid, e.id);
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid_end", bvalid, 0);
  endtask

  initial begin
    rst = 1'b1;
    araddr = 0; arvalid = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
    awaddr = 0; awvalid = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    wdata = 0; wstrb = 0; wvalid = 0; wlast = 0; bready = 0;
    mdl_wr = 1'b0; mdl_wbe = 8'd0; mdl_wdata = 64'd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", arready, 0);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rid", rid, 0);
    check("rst_bresp", bresp, 0);
    check("rst_bid", bid, 0);
    #2 rst = 1'b0;
    #1;
    check("rel_arready", arready, 1);
    check("rel_awready", awready, 1);

    repeat (10) @(posedge clk);
    #1;
    rd(BASE, 8'd0, 2'b01, 4'h3, 0, -1);                // single read after idle
    rd(BASE, 8'd1, 2'b01, 4'h5, 0, -1);                // lo then hi of one snapshot
    rd(BASE + 32'd8, 8'd0, 2'b01, 4'h7, 3, -1);        // unmapped, held 3 cycles
    rd(BASE + 32'd4, 8'd3, 2'b00, 4'h2, 0, -1);        // FIXED on the high word
    rd(BASE, 8'd3, 2'b01, 4'h9, 1, -1);                // INCR runs off the map
    rd(BASE, 8'd1, 2'b10, 4'hB, 0, -1);                // WRAP behaves as INCR
    rd(BASE, 8'd255, 2'b00, 4'hC, 0, -1);              // 256-beat burst

    wr(BASE, 8'd0, 4'hA, 32'h1234_5678, 4'b0011, 0);
    rd(BASE, 8'd1, 2'b01, 4'h1, 0, -1);
    wr(BASE, 8'd2, 4'h6, 32'hDEAD_BEEF, 4'b0000, 1);   // wlast early, 3 beats drained
`ifdef YSYX_23060229_CLINT_WRITE_EN
    wr(BASE, 8'd0, 4'h4, 32'hFFFF_FFFE, 4'b1111, 0);
    rd(BASE, 8'd1, 2'b01, 4'h5, 0, -1);
    wr(BASE + 32'd4, 8'd0, 4'h3, 32'h0000_00A5, 4'b0001, 0);
    wr(BASE + 32'd8, 8'd0, 4'h2, 32'hFFFF_FFFF, 4'b1111, 0);
    rd(BASE, 8'd1, 2'b01, 4'h8, 0, -1);
`endif

    rd(BASE, 8'd7, 2'b01, 4'h4, 0, 2);                 // reset while beat 3 is up
    @(posedge clk); #1;
    check("inrst_rvalid", rvalid, 0);
    #2 rst = 1'b0;
    #1;
    check("post_arready", arready, 1);
    check("post_awready", awready, 1);
    check("post_rvalid", rvalid, 0);
    @(posedge clk); #1;
    check("post_rvalid2", rvalid, 0);
    rd(BASE, 8'd1, 2'b01, 4'hE, 0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
